sec_tick_timer: RTL and testbench

//   Consumer side of the clock divisor: takes the slow 1 Hz square wave
//   (clk_one_sec) as a level input in the 100 MHz domain.

---
 rtl/sec_tick_timer.sv | 134 +++++++++++++
 tb/tb_sec_tick_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sec_tick_timer.sv
// sec_tick_timer: turns the divided 1 Hz square wave into a one-cycle tick and
// uses it to run a loadable mm:ss countdown with start/pause control.
// Every flop is clocked by clk. sec_in is sampled only as a level.
//
// Ports
//   clk      in   system clock; all logic runs on posedge
//   rst      in   synchronous, active-high reset
//   sec_in   in   1 Hz square wave from the divisor (asynchronous level)
//   load     in   1-cycle strobe: load load_min:load_sec (clamped), go to IDLE
//   load_min in   minutes to load
//   load_sec in   seconds to load
//   start    in   1-cycle strobe: IDLE/PAUSED -> RUN (or DONE if 00:00)
//   pause    in   1-cycle strobe: RUN -> PAUSED
//   tick     out  1-cycle pulse per sec_in rising edge, in every state
//   min      out  current minutes, 0..MAX_MIN
//   sec      out  current seconds, 0..59
//   running  out  high while the timer is in RUN
//   done     out  1-cycle pulse when the count reaches 00:00
module sec_tick_timer #(
  parameter int unsigned MAX_MIN  = 59,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_in,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic       tick,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done
);

  localparam logic [5:0] MaxMin = 6'(MAX_MIN);
  localparam logic [5:0] MaxSec = 6'd59;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Tick path: synchroniser, then an edge stage.
  // A rising edge first sampled at edge k makes tick high from edge
  // k + SYNC_LEN + 1 for exactly one cycle.
  // ---------------------------------------------------------------------------
  logic [SYNC_LEN-1:0] sync_q;
  logic                edge_q;
  logic                prev_q;
  logic                tick_q;
  logic                sync_out;

  assign sync_out = sync_q[SYNC_LEN-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_LEN-2:0], sec_in};
      edge_q <= sync_out;
      prev_q <= edge_q;
      tick_q <= edge_q & ~prev_q;
    end
  end

  assign tick = tick_q;

  // ---------------------------------------------------------------------------
  // Countdown FSM: state register / next-state / output decode.
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       running_q, running_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Priority: load > pause > start > tick-decrement.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (load) begin
      min_d   = (load_min > MaxMin) ? MaxMin : load_min;
      sec_d   = (load_sec > MaxSec) ? MaxSec : load_sec;
      state_d = StIdle;
    end else if (pause && state_q == StRun) begin
      state_d = StPaused;
    end else if (start && (state_q == StIdle || state_q == StPaused)) begin
      state_d = (min_q == '0 && sec_q == '0) ? StDone : StRun;
    end else if (tick_q && state_q == StRun) begin
      if (sec_q != '0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != '0) begin
        sec_d = MaxSec;
        min_d = min_q - 6'd1;
      end
      if (min_d == '0 && sec_d == '0) begin
        state_d = StDone;
      end
    end
  end

  // Outputs are registered from the next state so they line up with min/sec.
  always_comb begin
    running_d = (state_d == StRun);
    done_d    = (state_d == StDone) && (state_q != StDone);
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sec_tick_timer.sv
// Directed bench for sec_tick_timer (SYNC_LEN = 2, MAX_MIN = 59).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_sec_tick_timer;

  logic       clk;
  logic       rst;
  logic       sec_in;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic       tick;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  sec_tick_timer #(
    .MAX_MIN  (59),
    .SYNC_LEN (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_in   (sec_in),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .min      (min),
    .sec      (sec),
    .running  (running),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    load_min = m;
    load_sec = s;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    step();
    pause = 1'b0;
  endtask

  task automatic check_mmss(input string tag, input int m, input int s);
    check_eq({tag, ".min"}, int'(min), m);
    check_eq({tag, ".sec"}, int'(sec), s);
  endtask

  // Let the tick path drain, raise sec_in, check the tick pulse, then take the
  // edge on which the timer consumes it (optionally with pause or load held).
  task automatic do_tick(input bit with_pause, input bit with_load,
                         input logic [5:0] m, input logic [5:0] s);
    repeat (4) step();
    sec_in = 1'b1;
    repeat (4) step();
    check_eq("tick_pulse", int'(tick), 1);
    sec_in = 1'b0;
    if (with_pause) pause = 1'b1;
    if (with_load) begin
      load_min = m;
      load_sec = s;
      load     = 1'b1;
    end
    step();
    pause = 1'b0;
    load  = 1'b0;
    check_eq("tick_one_cycle", int'(tick), 0);
  endtask

  initial begin
    rst      = 1'b1;
    sec_in   = 1'b1;
    load     = 1'b0;
    load_min = '0;
    load_sec = '0;
    start    = 1'b0;
    pause    = 1'b0;

    // 1: reset with sec_in high, then one tick at edge k+3 (k = first
    //    non-reset edge).
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst.tick", int'(tick), 0);
      check_eq("rst.running", int'(running), 0);
      check_eq("rst.done", int'(done), 0);
      check_mmss("rst", 0, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("post_rst_tick_%0d", i), int'(tick), (i == 3) ? 1 : 0);
    end
    sec_in = 1'b0;

    // 2: 00:03 counts down to 00:00, done pulses with the final update.
    do_load(6'd0, 6'd3);
    check_mmss("t2_load", 0, 3);
    do_start();
    check_eq("t2_running", int'(running), 1);
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t2_a", 0, 2);
    check_eq("t2_a_done", int'(done), 0);
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t2_b", 0, 1);
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t2_c", 0, 0);
    check_eq("t2_done", int'(done), 1);
    check_eq("t2_running_fall", int'(running), 0);
    step();
    check_eq("t2_done_1cyc", int'(done), 0);
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t2_hold_done", 0, 0);

    // 3: 01:00 borrows into 00:59 and keeps running.
    do_load(6'd1, 6'd0);
    do_start();
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t3", 0, 59);
    check_eq("t3_running", int'(running), 1);

    // 4: pause holds the count, start resumes it.
    do_load(6'd0, 6'd5);
    do_start();
    do_tick(1'b0, 1'b0, '0, '0);
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t4_run", 0, 3);
    do_pause();
    check_eq("t4_paused", int'(running), 0);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 1'b0, '0, '0);
      check_mmss("t4_hold", 0, 3);
    end
    do_start();
    check_eq("t4_resumed", int'(running), 1);
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t4_after", 0, 2);

    // 5: start at 00:00 goes straight to DONE; oversize loads clamp
    //    (ports are 6 bits, so 63 and 60 stand in for out-of-range values).
    do_load(6'd0, 6'd0);
    do_start();
    check_eq("t5_done", int'(done), 1);
    check_eq("t5_running", int'(running), 0);
    step();
    check_eq("t5_done_1cyc", int'(done), 0);
    do_start();
    check_eq("t5_restart_ignored", int'(done), 0);
    do_load(6'd63, 6'd63);
    check_mmss("t5_clamp63", 59, 59);
    do_load(6'd60, 6'd60);
    check_mmss("t5_clamp60", 59, 59);
    do_load(6'd59, 6'd59);
    check_mmss("t5_max", 59, 59);

    // 6: pause coinciding with a tick wins; load coinciding with a tick wins.
    do_load(6'd0, 6'd10);
    do_start();
    do_tick(1'b1, 1'b0, '0, '0);
    check_mmss("t6_pause_tick", 0, 10);
    check_eq("t6_paused", int'(running), 0);
    do_start();
    do_tick(1'b0, 1'b1, 6'd0, 6'd20);
    check_mmss("t6_load_tick", 0, 20);
    check_eq("t6_idle", int'(running), 0);

    // Reset mid-count returns to IDLE at 00:00.
    do_start();
    do_tick(1'b0, 1'b0, '0, '0);
    check_mmss("t7_run", 0, 19);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_mmss("t7_rst", 0, 0);
    check_eq("t7_rst_running", int'(running), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
